fetch_sequencer: RTL and testbench

//  Moore control sequencer for the PC / MUX_PC / MUX_ADDR / MAR / IR fetch datapath.

---
 rtl/fetch_sequencer_pkg.sv | 70 +++++++
 rtl/fetch_sequencer_wait_timer.sv | 31 +++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: state codes, mux selects and the
// single-bit control word decoded from each state.
package fetch_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_VECTOR  = 4'd1,
        ST_FETCH   = 4'd2,
        ST_READ    = 4'd3,
        ST_LOAD_IR = 4'd4,
        ST_DECODE  = 4'd5,
        ST_EXEC    = 4'd6,
        ST_BRANCH  = 4'd7,
        ST_HALT    = 4'd8,
        ST_FAULT   = 4'd9
    } state_t;

    localparam logic [7:0] PC_SRC_INC    = 8'd0;
    localparam logic [7:0] PC_SRC_BRANCH = 8'd1;
    localparam logic [7:0] PC_SRC_VECTOR = 8'd2;
    localparam logic [7:0] ADDR_SRC_PC   = 8'd0;

    typedef struct packed {
        logic pc_rst_n;
        logic pc_ld_n;
        logic pc_inc_n;
        logic mar_rst_n;
        logic mar_ld_n;
        logic ir_ld_n;
        logic mem_rd_n;
        logic decode;
        logic halted;
        logic fault;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_rst_n: 1'b1, pc_ld_n: 1'b1, pc_inc_n: 1'b1, mar_rst_n: 1'b1,
        mar_ld_n: 1'b1, ir_ld_n: 1'b1, mem_rd_n: 1'b1,
        decode: 1'b0, halted: 1'b0, fault: 1'b0
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_rst_n: 1'b0, pc_ld_n: 1'b1, pc_inc_n: 1'b1, mar_rst_n: 1'b0,
        mar_ld_n: 1'b1, ir_ld_n: 1'b1, mem_rd_n: 1'b1,
        decode: 1'b0, halted: 1'b0, fault: 1'b0
    };

    // Moore decode: each state drives at most its own strobes over the idle word.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            ST_RESET:   c = CTRL_RESET;
            ST_VECTOR:  c.pc_ld_n  = 1'b0;
            ST_FETCH:   c.mar_ld_n = 1'b0;
            ST_READ:    c.mem_rd_n = 1'b0;
            ST_LOAD_IR: begin
                c.ir_ld_n  = 1'b0;
                c.pc_inc_n = 1'b0;
            end
            ST_DECODE:  c.decode   = 1'b1;
            ST_BRANCH:  c.pc_ld_n  = 1'b0;
            ST_HALT:    c.halted   = 1'b1;
            ST_FAULT:   c.fault    = 1'b1;
            default:    c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Saturating 8-bit READ wait counter; expired flags the last permitted wait cycle.
module fetch_sequencer_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT_LAST = 8'(LIMIT - 1);

    logic [7:0] wait_cnt_r;

    // Wait counter: cleared before each READ, counts not-ready cycles, sticks at all-ones.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_cnt_r <= 8'd0;
        end else if (clear) begin
            wait_cnt_r <= 8'd0;
        end else if (enable && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign expired = (wait_cnt_r == LIMIT_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Moore fetch sequencer: reset vector, then FETCH/READ/LOAD_IR/DECODE/EXEC with
// memory-timeout FAULT, BRANCH reload and terminal HALT.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_SELECT_SIZE   = 3,
    parameter int unsigned ADDR_SELECT_SIZE = 2,
    parameter int unsigned WAIT_LIMIT       = 15,
    parameter int unsigned COUNT_WIDTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        mem_ready_i,
    input  logic                        exec_done_i,
    input  logic                        branch_i,
    input  logic                        halt_i,
    output logic                        pc_rst_no,
    output logic                        pc_ld_no,
    output logic                        pc_inc_no,
    output logic                        mar_rst_no,
    output logic                        mar_ld_no,
    output logic                        ir_ld_no,
    output logic                        mem_rd_no,
    output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
    output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
    output logic                        decode_o,
    output logic                        halted_o,
    output logic                        fault_o,
    output logic [COUNT_WIDTH-1:0]      fetch_count_o
);

    state_t                      state_r;
    state_t                      state_next_s;
    ctrl_t                       ctrl_next_s;
    ctrl_t                       ctrl_r;
    logic [PC_SELECT_SIZE-1:0]   pc_src_next_s;
    logic [PC_SELECT_SIZE-1:0]   pc_src_r;
    logic [ADDR_SELECT_SIZE-1:0] addr_src_next_s;
    logic [ADDR_SELECT_SIZE-1:0] addr_src_r;
    logic [COUNT_WIDTH-1:0]      fetch_count_r;
    logic                        timer_clear_s;
    logic                        timer_enable_s;
    logic                        timer_expired_s;

    assign timer_clear_s  = (state_r == ST_FETCH);
    assign timer_enable_s = (state_r == ST_READ) && !mem_ready_i;

    fetch_sequencer_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear    (timer_clear_s),
        .enable   (timer_enable_s),
        .expired  (timer_expired_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; unused encodings recover through RESET.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RESET:   state_next_s = ST_VECTOR;
            ST_VECTOR:  state_next_s = ST_FETCH;
            ST_FETCH:   state_next_s = ST_READ;
            ST_READ: begin
                if (mem_ready_i) begin
                    state_next_s = ST_LOAD_IR;
                end else if (timer_expired_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_LOAD_IR: state_next_s = ST_DECODE;
            ST_DECODE:  state_next_s = ST_EXEC;
            ST_EXEC: begin
                if (!exec_done_i) begin
                    state_next_s = ST_EXEC;
                end else if (halt_i) begin
                    state_next_s = ST_HALT;
                end else if (branch_i) begin
                    state_next_s = ST_BRANCH;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_BRANCH:  state_next_s = ST_FETCH;
            ST_HALT:    state_next_s = ST_HALT;
            ST_FAULT:   state_next_s = ST_FAULT;
            default:    state_next_s = ST_RESET;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs track state_r exactly.
    always_comb begin
        ctrl_next_s     = decode_ctrl(state_next_s);
        addr_src_next_s = ADDR_SELECT_SIZE'(ADDR_SRC_PC);
        case (state_next_s)
            ST_VECTOR: pc_src_next_s = PC_SELECT_SIZE'(PC_SRC_VECTOR);
            ST_BRANCH: pc_src_next_s = PC_SELECT_SIZE'(PC_SRC_BRANCH);
            default:   pc_src_next_s = PC_SELECT_SIZE'(PC_SRC_INC);
        endcase
    end

    // Output register; reset forces the RESET-state control word without a clock.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ctrl_r     <= CTRL_RESET;
            pc_src_r   <= PC_SELECT_SIZE'(PC_SRC_INC);
            addr_src_r <= ADDR_SELECT_SIZE'(ADDR_SRC_PC);
        end else begin
            ctrl_r     <= ctrl_next_s;
            pc_src_r   <= pc_src_next_s;
            addr_src_r <= addr_src_next_s;
        end
    end

    // Completed IR loads, wrapping.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fetch_count_r <= {COUNT_WIDTH{1'b0}};
        end else if (state_r == ST_LOAD_IR) begin
            fetch_count_r <= fetch_count_r + COUNT_WIDTH'(1);
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign pc_rst_no     = ctrl_r.pc_rst_n;
    assign pc_ld_no      = ctrl_r.pc_ld_n;
    assign pc_inc_no     = ctrl_r.pc_inc_n;
    assign mar_rst_no    = ctrl_r.mar_rst_n;
    assign mar_ld_no     = ctrl_r.mar_ld_n;
    assign ir_ld_no      = ctrl_r.ir_ld_n;
    assign mem_rd_no     = ctrl_r.mem_rd_n;
    assign decode_o      = ctrl_r.decode;
    assign halted_o      = ctrl_r.halted;
    assign fault_o       = ctrl_r.fault;
    assign pc_src_o      = pc_src_r;
    assign addr_src_o    = addr_src_r;
    assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench: a PC/MAR stub follows the control strobes, expected events
// are queued ahead by the stimulus and popped by an independent monitor.
module tb_fetch_sequencer;

    localparam int K_NONE  = 0;
    localparam int K_PCLD  = 1;
    localparam int K_MAR   = 2;
    localparam int K_IR    = 3;
    localparam int K_DEC   = 4;
    localparam int K_HALT  = 5;
    localparam int K_FAULT = 6;
    localparam logic [7:0] BR_TARGET = 8'h40;

    typedef struct {
        int         kind;
        logic [7:0] value;
    } exp_t;

    logic       clk;
    logic       reset_ni;
    logic       mem_ready_i;
    logic       exec_done_i;
    logic       branch_i;
    logic       halt_i;
    logic       pc_rst_no;
    logic       pc_ld_no;
    logic       pc_inc_no;
    logic       mar_rst_no;
    logic       mar_ld_no;
    logic       ir_ld_no;
    logic       mem_rd_no;
    logic [2:0] pc_src_o;
    logic [1:0] addr_src_o;
    logic       decode_o;
    logic       halted_o;
    logic       fault_o;
    logic [7:0] fetch_count_o;

    logic [7:0] pc_m;
    logic [7:0] mar_m;
    int         cyc;
    int         last_fetch_cyc;
    int         tests_run;
    int         tests_failed;
    exp_t       sb_q[$];

    fetch_sequencer #(
        .PC_SELECT_SIZE   (3),
        .ADDR_SELECT_SIZE (2),
        .WAIT_LIMIT       (15),
        .COUNT_WIDTH      (8)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .mem_ready_i   (mem_ready_i),
        .exec_done_i   (exec_done_i),
        .branch_i      (branch_i),
        .halt_i        (halt_i),
        .pc_rst_no     (pc_rst_no),
        .pc_ld_no      (pc_ld_no),
        .pc_inc_no     (pc_inc_no),
        .mar_rst_no    (mar_rst_no),
        .mar_ld_no     (mar_ld_no),
        .ir_ld_no      (ir_ld_no),
        .mem_rd_no     (mem_rd_no),
        .pc_src_o      (pc_src_o),
        .addr_src_o    (addr_src_o),
        .decode_o      (decode_o),
        .halted_o      (halted_o),
        .fault_o       (fault_o),
        .fetch_count_o (fetch_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath stub: PC and MAR registers steered by the sequencer strobes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!pc_rst_no) begin
            pc_m <= 8'h00;
        end else if (!pc_ld_no) begin
            pc_m <= (pc_src_o == 3'd2) ? 8'hFF : ((pc_src_o == 3'd1) ? BR_TARGET : pc_m);
        end else if (!pc_inc_no) begin
            pc_m <= pc_m + 8'd1;
        end
        if (!mar_rst_no) begin
            mar_m <= 8'h00;
        end else if (!mar_ld_no) begin
            mar_m <= (addr_src_o == 2'd0) ? pc_m : 8'h00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        sb_q.push_back(e);
    endtask

    function automatic logic [22:0] out_vec();
        return {pc_rst_no, pc_ld_no, pc_inc_no, mar_rst_no, mar_ld_no, ir_ld_no,
                mem_rd_no, pc_src_o, addr_src_o, decode_o, halted_o, fault_o, fetch_count_o};
    endfunction

    function automatic logic [22:0] reset_vec();
        return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 8'd0};
    endfunction

    // Monitor: classify each strobe cycle and compare it with the next queued event.
    initial begin : monitor
        int         kind;
        logic [7:0] value;
        logic       halted_q;
        logic       fault_q;
        exp_t       e;
        halted_q = 1'b0;
        fault_q  = 1'b0;
        forever begin
            @(negedge clk);
            kind  = K_NONE;
            value = 8'd0;
            if (!pc_ld_no) begin
                kind  = K_PCLD;
                value = {5'd0, pc_src_o};
            end else if (!mar_ld_no) begin
                kind  = K_MAR;
                value = pc_m;
            end else if (!ir_ld_no) begin
                kind  = K_IR;
                value = mar_m;
            end else if (decode_o) begin
                kind  = K_DEC;
                value = fetch_count_o;
            end else if (halted_o && !halted_q) begin
                kind  = K_HALT;
                value = fetch_count_o;
            end else if (fault_o && !fault_q) begin
                kind  = K_FAULT;
                value = fetch_count_o;
            end
            halted_q = halted_o;
            fault_q  = fault_o;
            if (!pc_ld_no || !pc_inc_no) begin
                check("ld_inc_exclusive", {31'd0, (!pc_ld_no && !pc_inc_no)}, 32'd0);
            end
            if (kind != K_NONE) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", kind, K_NONE);
                end else begin
                    e = sb_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("event_value", {24'd0, value}, {24'd0, e.value});
                end
            end
        end
    end

    // Hold reset three cycles, release, and check the vector load and first MAR load.
    task automatic restart(input logic ready);
        reset_ni = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), reset_vec());
        mem_ready_i = ready;
        reset_ni    = 1'b1;
        @(negedge clk);
        check("vector_ld", {28'd0, pc_ld_no, pc_src_o}, {28'd0, 1'b0, 3'd2});
        @(negedge clk);
        check("fetch_mar_ld", {31'd0, mar_ld_no}, 32'd0);
        check("pc_vector", {24'd0, pc_m}, 32'h0000_00FF);
        last_fetch_cyc = cyc;
        @(negedge clk);
        check("mar_after_3", {24'd0, mar_m}, 32'h0000_00FF);
        check("read_strobe", {31'd0, mem_rd_no}, 32'd0);
    endtask

    task automatic wait_decode();
        int n;
        n = 0;
        while (!decode_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("decode_reached", {31'd0, decode_o}, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int rd;
        int lds;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset_ni     = 1'b0;
        mem_ready_i  = 1'b0;
        exec_done_i  = 1'b0;
        branch_i     = 1'b0;
        halt_i       = 1'b0;

        push(K_PCLD, 8'd2);  push(K_MAR, 8'hFF); push(K_IR, 8'hFF); push(K_DEC, 8'd1);
        push(K_MAR, 8'h00);  push(K_IR, 8'h00);  push(K_DEC, 8'd2);
        push(K_MAR, 8'h01);  push(K_IR, 8'h01);  push(K_DEC, 8'd3);
        push(K_MAR, 8'h02);  push(K_IR, 8'h02);  push(K_DEC, 8'd4);
        push(K_PCLD, 8'd1);  push(K_MAR, BR_TARGET); push(K_IR, BR_TARGET); push(K_DEC, 8'd5);
        push(K_HALT, 8'd5);
        restart(1'b1);

        // Three zero-wait instructions, exec_done on the first EXEC cycle.
        for (int i = 0; i < 3; i++) begin
            wait_decode();
            @(negedge clk);
            exec_done_i = 1'b1;
            @(negedge clk);
            exec_done_i = 1'b0;
            check("fetch_after_exec", {31'd0, mar_ld_no}, 32'd0);
            check("instr_cycles", cyc - last_fetch_cyc, 32'd5);
            last_fetch_cyc = cyc;
        end
        check("fetch_count_3", {24'd0, fetch_count_o}, 32'd3);
        check("pc_after_3", {24'd0, pc_m}, 32'h0000_0002);

        // Four not-ready READ cycles, ready on the fifth.
        mem_ready_i = 1'b0;
        @(negedge clk);
        rd = 0;
        while (!mem_rd_no && rd < 40) begin
            rd++;
            if (rd == 5) mem_ready_i = 1'b1;
            @(negedge clk);
        end
        check("read_cycles_5", rd, 32'd5);
        check("ir_pulse_on", {31'd0, ir_ld_no}, 32'd0);
        @(negedge clk);
        check("ir_pulse_single", {30'd0, ir_ld_no, decode_o}, {30'd0, 1'b1, 1'b1});
        check("no_fault_wait", {31'd0, fault_o}, 32'd0);

        // Branch.
        @(negedge clk);
        exec_done_i = 1'b1;
        branch_i    = 1'b1;
        @(negedge clk);
        exec_done_i = 1'b0;
        branch_i    = 1'b0;
        check("branch_ld", {27'd0, pc_ld_no, pc_inc_no, pc_src_o}, {27'd0, 1'b0, 1'b1, 3'd1});
        @(negedge clk);
        check("branch_one_cycle", {31'd0, pc_ld_no}, 32'd1);
        check("pc_branch", {24'd0, pc_m}, {24'd0, BR_TARGET});

        // Halt wins over branch.
        wait_decode();
        @(negedge clk);
        exec_done_i = 1'b1;
        halt_i      = 1'b1;
        branch_i    = 1'b1;
        @(negedge clk);
        exec_done_i = 1'b0;
        halt_i      = 1'b0;
        branch_i    = 1'b0;
        check("halt_entered", {30'd0, halted_o, pc_ld_no}, {30'd0, 1'b1, 1'b1});
        lds = 0;
        repeat (6) begin
            @(negedge clk);
            if (!pc_ld_no) lds++;
        end
        check("halt_no_pc_ld", lds, 32'd0);
        check("halt_sticky", {31'd0, halted_o}, 32'd1);
        check("pc_halt", {24'd0, pc_m}, 32'h0000_0041);
        check("fetch_count_5", {24'd0, fetch_count_o}, 32'd5);

        // Asynchronous reset while halted.
        #2 reset_ni = 1'b0;
        #1 check("async_reset_halt", out_vec(), reset_vec());
        @(negedge clk);
        push(K_PCLD, 8'd2); push(K_MAR, 8'hFF); push(K_IR, 8'hFF); push(K_DEC, 8'd1);
        push(K_MAR, 8'h00);
        restart(1'b1);
        wait_decode();
        @(negedge clk);
        exec_done_i = 1'b1;
        @(negedge clk);
        exec_done_i = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_read", {31'd0, mem_rd_no}, 32'd0);
        #2 reset_ni = 1'b0;
        #1 check("async_reset_read", out_vec(), reset_vec());

        // Memory never ready: FAULT after WAIT_LIMIT READ cycles.
        @(negedge clk);
        push(K_PCLD, 8'd2); push(K_MAR, 8'hFF); push(K_FAULT, 8'd0);
        restart(1'b0);
        rd = 0;
        while (!fault_o && rd < 40) begin
            if (!mem_rd_no) rd++;
            @(negedge clk);
        end
        check("timeout_cycles", rd, 32'd15);
        mem_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        check("fault_sticky", {30'd0, fault_o, mem_rd_no}, {30'd0, 1'b1, 1'b1});

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
